// File: rtl/alu_multicycle.sv
// Execute-stage ALU with valid/ready handshakes and a registered result.
// Multiply is iterative; define ALU_DIV_EN to add the iterative signed divider.
module alu_multicycle #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [3:0]      alu_mode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            busy
);

  localparam int unsigned CntW = $clog2(XLEN);

  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [3:0] ModeAdd  = 4'b0010;
  localparam logic [3:0] ModeSub  = 4'b0110;
  localparam logic [3:0] ModeAnd  = 4'b0000;
  localparam logic [3:0] ModeOr   = 4'b0001;
  localparam logic [3:0] ModeXor  = 4'b0011;
  localparam logic [3:0] ModeMul  = 4'b0100;
  localparam logic [3:0] ModeSll  = 4'b1000;
  localparam logic [3:0] ModeSrl  = 4'b1100;
  localparam logic [3:0] ModeSra  = 4'b1101;
  localparam logic [3:0] ModeSlt  = 4'b0111;
  localparam logic [3:0] ModeSltu = 4'b1001;
`ifdef ALU_DIV_EN
  localparam logic [3:0] ModeDiv  = 4'b0101;
  localparam logic [3:0] ModeRem  = 4'b1010;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;
`endif

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [XLEN-1:0]   result_q;
  logic              br_q;
  logic [XLEN-1:0]   acc_q;
  logic [XLEN-1:0]   opa_q;
  logic [XLEN-1:0]   opb_q;

  logic [XLEN-1:0]    alu_res;
  logic               br_cond;
  logic [XLEN-1:0]    mul_acc_d;
  logic [SHAMT_W-1:0] shamt;

  assign shamt        = b[SHAMT_W-1:0];
  assign result       = result_q;
  assign branch_taken = br_q;
  assign out_valid    = (state_q == StDone);
  assign in_ready     = !flush && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
`ifdef ALU_DIV_EN
  assign busy         = (state_q == StMul) || (state_q == StDiv);
`else
  assign busy         = (state_q == StMul);
`endif

  always_comb begin
    alu_res = '0;
    case (alu_mode)
      ModeAdd:  alu_res = a + b;
      ModeSub:  alu_res = a - b;
      ModeAnd:  alu_res = a & b;
      ModeOr:   alu_res = a | b;
      ModeXor:  alu_res = a ^ b;
      ModeSll:  alu_res = a << shamt;
      ModeSrl:  alu_res = a >> shamt;
      ModeSra:  alu_res = $unsigned($signed(a) >>> shamt);
      ModeSlt:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ModeSltu: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      3'b000:  br_cond = (a == b);
      3'b001:  br_cond = (a != b);
      3'b100:  br_cond = ($signed(a) < $signed(b));
      3'b101:  br_cond = ($signed(a) >= $signed(b));
      3'b110:  br_cond = (a < b);
      3'b111:  br_cond = (a >= b);
      default: br_cond = 1'b0;
    endcase
  end

  // Shift-add: opa_q is the multiplicand shifted left, opb_q the multiplier shifted right.
  assign mul_acc_d = acc_q + (opb_q[0] ? opa_q : '0);

`ifdef ALU_DIV_EN
  logic [XLEN-1:0] rem_q;
  logic            is_rem_q;
  logic            neg_q;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic [XLEN-1:0] div_r_d;
  logic [XLEN-1:0] div_q_d;
  logic [XLEN-1:0] div_raw;
  logic [XLEN-1:0] div_fix;

  // Restoring step: opa_q holds the dividend magnitude shifting into the quotient.
  always_comb begin
    div_shift = {rem_q, opa_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (div_diff[XLEN]) begin
      div_r_d = div_shift[XLEN-1:0];
      div_q_d = {opa_q[XLEN-2:0], 1'b0};
    end else begin
      div_r_d = div_diff[XLEN-1:0];
      div_q_d = {opa_q[XLEN-2:0], 1'b1};
    end
    div_raw = is_rem_q ? div_r_d : div_q_d;
    div_fix = neg_q ? (-div_raw) : div_raw;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      result_q <= '0;
      br_q     <= 1'b0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
`ifdef ALU_DIV_EN
      rem_q    <= '0;
      is_rem_q <= 1'b0;
      neg_q    <= 1'b0;
`endif
    end else if (flush) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if ((state_q == StDone) && out_ready) state_q <= StIdle;
          if (in_valid && in_ready) begin
            if (opcode == OpBranch) begin
              result_q <= a - b;
              br_q     <= br_cond;
              state_q  <= StDone;
            end else if (alu_mode == ModeMul) begin
              acc_q   <= '0;
              opa_q   <= a;
              opb_q   <= b;
              cnt_q   <= '0;
              br_q    <= 1'b0;
              state_q <= StMul;
`ifdef ALU_DIV_EN
            end else if ((alu_mode == ModeDiv) || (alu_mode == ModeRem)) begin
              opa_q    <= a[XLEN-1] ? (-a) : a;
              opb_q    <= b[XLEN-1] ? (-b) : b;
              rem_q    <= '0;
              is_rem_q <= (alu_mode == ModeRem);
              // Divide by zero leaves an all-ones quotient, which must not be negated.
              neg_q    <= (alu_mode == ModeRem) ? a[XLEN-1] :
                          ((a[XLEN-1] ^ b[XLEN-1]) && (b != '0));
              cnt_q    <= '0;
              br_q     <= 1'b0;
              state_q  <= StDiv;
`endif
            end else begin
              result_q <= alu_res;
              br_q     <= 1'b0;
              state_q  <= StDone;
            end
          end
        end
        StMul: begin
          acc_q <= mul_acc_d;
          opa_q <= opa_q << 1;
          opb_q <= opb_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(XLEN - 1)) begin
            result_q <= mul_acc_d;
            cnt_q    <= '0;
            state_q  <= StDone;
          end
        end
`ifdef ALU_DIV_EN
        StDiv: begin
          opa_q <= div_q_d;
          rem_q <= div_r_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(XLEN - 1)) begin
            result_q <= div_fix;
            cnt_q    <= '0;
            state_q  <= StDone;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle; expectations follow ALU_DIV_EN when it is defined.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  bit          clk_en = 1'b1;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [3:0]  alu_mode;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        branch_taken;
  logic        busy;

  int total = 0;
  int bad = 0;
  logic [31:0] last_res = '0;

  localparam logic [6:0] OpBr = 7'b1100011;
  localparam logic [6:0] OpAlu = 7'b0110011;

  alu_multicycle #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .funct3       (funct3),
    .alu_mode     (alu_mode),
    .a            (a),
    .b            (b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .branch_taken (branch_taken),
    .busy         (busy)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour straight from the operation definitions.
  function automatic void ref_model(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [3:0] md, input logic [31:0] aa,
                                    input logic [31:0] bb, output logic [31:0] res,
                                    output logic br, output int lat);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = aa;
    sb = bb;
    res = '0;
    br = 1'b0;
    lat = 1;
    if (op == OpBr) begin
      res = aa - bb;
      case (f3)
        3'b000: br = (aa == bb);
        3'b001: br = (aa != bb);
        3'b100: br = (sa < sb);
        3'b101: br = (sa >= sb);
        3'b110: br = (aa < bb);
        3'b111: br = (aa >= bb);
        default: br = 1'b0;
      endcase
    end else begin
      case (md)
        4'b0010: res = aa + bb;
        4'b0110: res = aa - bb;
        4'b0000: res = aa & bb;
        4'b0001: res = aa | bb;
        4'b0011: res = aa ^ bb;
        4'b1000: res = aa << bb[4:0];
        4'b1100: res = aa >> bb[4:0];
        4'b1101: res = sa >>> bb[4:0];
        4'b0111: res = (sa < sb) ? 32'd1 : 32'd0;
        4'b1001: res = (aa < bb) ? 32'd1 : 32'd0;
        4'b0100: begin res = aa * bb; lat = 33; end
`ifdef ALU_DIV_EN
        4'b0101: begin
          lat = 33;
          if (bb == 0) res = 32'hFFFFFFFF;
          else if (aa == 32'h80000000 && bb == 32'hFFFFFFFF) res = 32'h80000000;
          else res = sa / sb;
        end
        4'b1010: begin
          lat = 33;
          if (bb == 0) res = aa;
          else if (aa == 32'h80000000 && bb == 32'hFFFFFFFF) res = 0;
          else res = sa % sb;
        end
`endif
        default: res = '0;
      endcase
    end
  endfunction

  task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [3:0] md,
                       input logic [31:0] aa, input logic [31:0] bb, input string name);
    logic [31:0] exp_res;
    logic exp_br;
    int exp_lat;
    int n;
    int lat;
    int busy_n;
    ref_model(op, f3, md, aa, bb, exp_res, exp_br, exp_lat);
    opcode = op; funct3 = f3; alu_mode = md; a = aa; b = bb; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL %s accept: in_ready=%b want 1", name, in_ready);
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    opcode = 7'($urandom); funct3 = 3'($urandom); alu_mode = 4'($urandom);
    a = $urandom; b = $urandom;
    lat = 1;
    busy_n = 0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_n++;
      tick();
      lat++;
    end
    total++;
    if (lat !== exp_lat) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    total++;
    if (result !== exp_res || branch_taken !== exp_br) begin
      bad++;
      $display("FAIL %s value: got res=%h br=%b want res=%h br=%b", name, result,
               branch_taken, exp_res, exp_br);
    end
    total++;
    if (busy_n !== exp_lat - 1) begin
      bad++;
      $display("FAIL %s busy: got %0d cycles want %0d", name, busy_n, exp_lat - 1);
    end
    last_res = exp_res;
    tick();
  endtask

  task automatic test_reset();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 ||
        branch_taken !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset: rdy=%b ov=%b res=%h br=%b busy=%b want 1 0 0 0 0", in_ready,
               out_valid, result, branch_taken, busy);
    end
  endtask

  task automatic test_basic();
    do_op(OpAlu, 3'b000, 4'b0010, 32'd5, 32'hFFFFFFF9, "add_5_m7");
    do_op(OpBr, 3'b000, 4'b0000, 32'd9, 32'd9, "beq_eq");
    do_op(OpBr, 3'b010, 4'b0000, 32'd9, 32'd9, "br_undef_f3");
    do_op(OpAlu, 3'b000, 4'b1101, 32'h80000010, 32'h00000024, "sra_shamt_mask");
    do_op(OpAlu, 3'b000, 4'b1111, 32'h12345678, 32'h1, "bad_mode");
  endtask

  task automatic test_random_single();
    logic [3:0] modes [12];
    logic [31:0] ra;
    logic [31:0] rb;
    modes = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b1000, 4'b1100, 4'b1101,
              4'b0111, 4'b1001, 4'b1011, 4'b1110};
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if (i % 3 == 0)
        do_op(OpBr, 3'($urandom), 4'($urandom), ra, rb, "rand_branch");
      else
        do_op(OpAlu, 3'($urandom), modes[$urandom_range(0, 11)], ra, rb, "rand_alu");
    end
  endtask

  task automatic test_mul();
    do_op(OpAlu, 3'b000, 4'b0100, 32'hFFFFFFFD, 32'd7, "mul_m3_7");
    for (int i = 0; i < 3; i++) do_op(OpAlu, 3'b000, 4'b0100, $urandom, $urandom, "mul_rand");
  endtask

  task automatic test_div();
    do_op(OpAlu, 3'b000, 4'b0101, 32'hFFFFFFF9, 32'd2, "div_m7_2");
    do_op(OpAlu, 3'b000, 4'b1010, 32'hFFFFFFF9, 32'd2, "rem_m7_2");
    do_op(OpAlu, 3'b000, 4'b0101, 32'd5, 32'd0, "div_by_0");
    do_op(OpAlu, 3'b000, 4'b1010, 32'hFFFFFFF3, 32'd0, "rem_by_0");
    do_op(OpAlu, 3'b000, 4'b0101, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    do_op(OpAlu, 3'b000, 4'b1010, 32'h80000000, 32'hFFFFFFFF, "rem_ovf");
    for (int i = 0; i < 3; i++) begin
      do_op(OpAlu, 3'b000, 4'b0101, $urandom, 32'($urandom_range(1, 5000)) * 32'hFFFFFFFF,
            "div_rand");
      do_op(OpAlu, 3'b000, 4'b1010, $urandom, $urandom, "rem_rand");
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] xa;
    logic [31:0] xb;
    out_ready = 1'b0;
    opcode = OpAlu; alu_mode = 4'b0010; a = 32'd100; b = 32'd23; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || result !== 32'd123) begin
      bad++;
      $display("FAIL bp_first: ov=%b res=%h want 1 0000007b", out_valid, result);
    end
    xa = $urandom;
    xb = $urandom;
    opcode = OpAlu; alu_mode = 4'b0011; a = xa; b = xb; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || result !== 32'd123 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold: ov=%b res=%h rdy=%b want 1 0000007b 0", out_valid, result,
                 in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: in_ready=%b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || result !== (xa ^ xb)) begin
      bad++;
      $display("FAIL bp_b2b: ov=%b res=%h want 1 %h", out_valid, result, xa ^ xb);
    end
    last_res = xa ^ xb;
    tick();
  endtask

  task automatic test_flush();
    opcode = OpAlu; alu_mode = 4'b0100; a = $urandom; b = $urandom; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL flush_during: rdy=%b busy=%b want 0 1", in_ready, busy);
    end
    tick();
    flush = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || result !== last_res) begin
      bad++;
      $display("FAIL flush_after: busy=%b ov=%b rdy=%b res=%h want 0 0 1 %h", busy, out_valid,
               in_ready, result, last_res);
    end
    tick();
    do_op(OpAlu, 3'b000, 4'b0010, 32'd40, 32'd2, "add_after_flush");
  endtask

  task automatic test_async_rst();
`ifdef ALU_DIV_EN
    alu_mode = 4'b0101;
`else
    alu_mode = 4'b0100;
`endif
    opcode = OpAlu; a = 32'hFFFFF000; b = 32'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    clk_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 ||
        branch_taken !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL async_rst: rdy=%b ov=%b res=%h br=%b busy=%b want 1 0 0 0 0", in_ready,
               out_valid, result, branch_taken, busy);
    end
    #1;
    rst = 1'b0;
    clk_en = 1'b1;
    last_res = '0;
    tick();
    do_op(OpBr, 3'b110, 4'b0000, 32'd1, 32'hFFFFFFFF, "bltu_after_rst");
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; funct3 = '0; alu_mode = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_random_single();
    test_mul();
    test_div();
    test_backpressure();
    test_flush();
    test_async_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
